// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle main FSM (master) and the datapath/decoders (slave).
interface multicycle_controller_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       NoWrite;
    logic       MemReady;
    logic       IRWrite;
    logic       NextPC;
    logic       RegW;
    logic       MemW;
    logic       MemReq;
    logic       Branch;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       ALUOp;
    logic       Illegal;

    modport master (
        input  Op, Funct, NoWrite, MemReady,
        output IRWrite, NextPC, RegW, MemW, MemReq, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal
    );

    modport slave (
        output Op, Funct, NoWrite, MemReady,
        input  IRWrite, NextPC, RegW, MemW, MemReq, Branch, AdrSrc,
               ALUSrcA, ALUSrcB, ResultSrc, ALUOp, Illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main Moore FSM sequencing the shared multicycle datapath (fetch/decode/execute/mem/writeback).
// Define MULTICYCLE_MEM_WAIT_EN to make FETCH/MEMREAD/MEMWRITE hold until MemReady.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECUTER = 4'd6;
    localparam logic [3:0] S_EXECUTEI = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;

    logic [3:0] state;
    logic [3:0] state_nxt;
    logic       mem_ready;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign mem_ready = bus.MemReady;
`else
    // Without the handshake every memory step completes in one cycle.
    assign mem_ready = bus.MemReady | 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) state <= S_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_FETCH;
        case (state)
            S_FETCH:    state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.Op)
                    2'b00:   state_nxt = bus.Funct[5] ? S_EXECUTEI : S_EXECUTER;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR:   state_nxt = bus.Funct[0] ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_nxt = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: state_nxt = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_nxt = S_ALUWB;
            S_EXECUTEI: state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_BRANCH:   state_nxt = S_FETCH;
            default:    state_nxt = S_FETCH;
        endcase
    end

    always_comb begin
        bus.IRWrite   = 1'b0;
        bus.NextPC    = 1'b0;
        bus.RegW      = 1'b0;
        bus.MemW      = 1'b0;
        bus.MemReq    = 1'b0;
        bus.Branch    = 1'b0;
        bus.AdrSrc    = 1'b0;
        bus.ALUSrcA   = 2'b00;
        bus.ALUSrcB   = 2'b00;
        bus.ResultSrc = 2'b00;
        bus.ALUOp     = 1'b0;
        bus.Illegal   = 1'b0;
        if (!reset) begin
            // Enables stay low during reset so an aborted instruction writes nothing.
            bus.ALUSrcA   = 2'b01;
            bus.ALUSrcB   = 2'b10;
            bus.ResultSrc = 2'b10;
        end else begin
            case (state)
                S_FETCH: begin
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    bus.MemReq    = 1'b1;
                    bus.IRWrite   = mem_ready;
                    bus.NextPC    = mem_ready;
                end
                S_DECODE: begin
                    bus.ALUSrcA   = 2'b01;
                    bus.ALUSrcB   = 2'b10;
                    bus.ResultSrc = 2'b10;
                    bus.Illegal   = (bus.Op == 2'b11);
                end
                S_MEMADR: begin
                    bus.ALUSrcB   = 2'b01;
                end
                S_MEMREAD: begin
                    bus.AdrSrc    = 1'b1;
                    bus.MemReq    = 1'b1;
                end
                S_MEMWB: begin
                    bus.ResultSrc = 2'b01;
                    bus.RegW      = 1'b1;
                end
                S_MEMWRITE: begin
                    bus.AdrSrc    = 1'b1;
                    bus.MemReq    = 1'b1;
                    bus.MemW      = 1'b1;
                end
                S_EXECUTER: begin
                    bus.ALUOp     = 1'b1;
                end
                S_EXECUTEI: begin
                    bus.ALUSrcB   = 2'b01;
                    bus.ALUOp     = 1'b1;
                end
                S_ALUWB: begin
                    bus.RegW      = ~bus.NoWrite;
                end
                S_BRANCH: begin
                    bus.ALUSrcA   = 2'b10;
                    bus.ALUSrcB   = 2'b01;
                    bus.ResultSrc = 2'b10;
                    bus.Branch    = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-cycle output words checked against hand-derived values.
module tb_multicycle_controller;
    logic clk;
    logic reset;
    int   total;
    int   bad;

    multicycle_controller_if bus();

    multicycle_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {IRWrite,NextPC,RegW,MemW,MemReq}_{Branch,AdrSrc}_ALUSrcA_ALUSrcB_ResultSrc_{ALUOp,Illegal}
    logic [14:0] outs;
    assign outs = {bus.IRWrite, bus.NextPC, bus.RegW, bus.MemW, bus.MemReq,
                   bus.Branch, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB,
                   bus.ResultSrc, bus.ALUOp, bus.Illegal};

    localparam logic [14:0] E_FETCH    = 15'b11001_00_01_10_10_00;
    localparam logic [14:0] E_FETCHW   = 15'b00001_00_01_10_10_00;
    localparam logic [14:0] E_DECODE   = 15'b00000_00_01_10_10_00;
    localparam logic [14:0] E_RESET    = 15'b00000_00_01_10_10_00;
    localparam logic [14:0] E_ILLEGAL  = 15'b00000_00_01_10_10_01;
    localparam logic [14:0] E_MEMADR   = 15'b00000_00_00_01_00_00;
    localparam logic [14:0] E_MEMREAD  = 15'b00001_01_00_00_00_00;
    localparam logic [14:0] E_MEMWB    = 15'b00100_00_00_00_01_00;
    localparam logic [14:0] E_MEMWRITE = 15'b00011_01_00_00_00_00;
    localparam logic [14:0] E_EXECR    = 15'b00000_00_00_00_00_10;
    localparam logic [14:0] E_EXECI    = 15'b00000_00_00_01_00_10;
    localparam logic [14:0] E_ALUWB    = 15'b00100_00_00_00_00_00;
    localparam logic [14:0] E_ALUWB_NW = 15'b00000_00_00_00_00_00;
    localparam logic [14:0] E_BRANCH   = 15'b00000_10_10_01_10_00;

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (outs !== E_RESET) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%b want=%b", i, outs, E_RESET);
            end
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_add_reg();
        logic [14:0] exp [5];
        exp = '{E_FETCH, E_DECODE, E_EXECR, E_ALUWB, E_FETCH};
        bus.Op = 2'b00; bus.Funct = 6'b001000; bus.NoWrite = 1'b0; bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL add_reg[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_cmp_imm();
        logic [14:0] exp [5];
        exp = '{E_FETCH, E_DECODE, E_EXECI, E_ALUWB_NW, E_FETCH};
        bus.Op = 2'b00; bus.Funct = 6'b110101; bus.NoWrite = 1'b1; bus.MemReady = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL cmp_imm[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
        bus.NoWrite = 1'b0;
    endtask

    task automatic test_ldr();
        logic [14:0] exp [8];
        logic        rdy [8];
        int          n;
`ifdef MULTICYCLE_MEM_WAIT_EN
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMREAD, E_MEMREAD, E_MEMWB, E_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n = 8;
`else
        // MemReady low is ignored here, so MEMREAD still lasts one cycle.
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_FETCH, E_FETCH, E_FETCH};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        n = 6;
`endif
        bus.Op = 2'b01; bus.Funct = 6'b011001;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            bus.MemReady = rdy[i];
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL ldr[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
        bus.MemReady = 1'b1;
    endtask

    task automatic test_fetch_wait();
        logic [14:0] exp [4];
`ifdef MULTICYCLE_MEM_WAIT_EN
        exp = '{E_FETCHW, E_FETCHW, E_FETCH, E_DECODE};
`else
        exp = '{E_FETCH, E_DECODE, E_EXECR, E_ALUWB};
`endif
        bus.Op = 2'b00; bus.Funct = 6'b001000;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            bus.MemReady = (i >= 2);
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL fetch_wait[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
        bus.MemReady = 1'b1;
        // Drain the remainder of this instruction back to FETCH.
        while (outs !== E_FETCH && total < 1000) begin
            @(negedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [14:0] exp [8];
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_MEMWRITE, E_FETCH, E_DECODE, E_BRANCH, E_FETCH};
        bus.Op = 2'b01; bus.Funct = 6'b011000; bus.MemReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 4) bus.Op = 2'b10;
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL str_b[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [14:0] exp [3];
        exp = '{E_FETCH, E_ILLEGAL, E_FETCH};
        bus.Op = 2'b11; bus.Funct = 6'b000000;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL illegal[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
    endtask

    task automatic test_abort();
        logic [14:0] exp [6];
        exp = '{E_FETCH, E_DECODE, E_MEMADR, E_RESET, E_FETCH, E_DECODE};
        bus.Op = 2'b01; bus.Funct = 6'b011000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            reset = (i != 3);
            if (i == 4) bus.Op = 2'b00;
            #1;
            total++;
            if (outs !== exp[i]) begin
                bad++;
                $display("FAIL abort[%0d] got=%b want=%b", i, outs, exp[i]);
            end
        end
        // Finish the data-processing instruction started after the abort.
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (outs !== E_FETCH) begin
            bad++;
            $display("FAIL abort_recover got=%b want=%b", outs, E_FETCH);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        bus.Op = 2'b00; bus.Funct = 6'b000000; bus.NoWrite = 1'b0; bus.MemReady = 1'b1;
        test_reset();
        test_add_reg();
        test_cmp_imm();
        test_ldr();
        test_fetch_wait();
        test_back_to_back();
        test_illegal();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control state machine for the multicycle ARM-subset processor. It sequences the shared datapath (single ALU, unified instruction/data memory, instruction register, PC) through fetch, decode, execute, memory and writeback steps. It also drives `ALUOp` into the ALU decoder, which selects the data-processing operation. It sits in the control unit beside the ALU decoder and the condition-check logic, which gate `RegW`, `MemW` and `Branch` further.

## Interface
- No parameters; all encodings are fixed.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low. 0 = reset.
- `Op` in 2: instruction bits [27:26]. 00 = data-processing, 01 = memory, 10 = branch, 11 = undefined.
- `Funct` in 6: instruction bits [25:20]. [5] = I (immediate), [0] = S for data-processing or L for memory.
- `NoWrite` in 1: from the ALU decoder. When 1 (CMP), the register write is suppressed.
- `MemReady` in 1: memory completion strobe. Used only with `MEM_WAIT_EN`.
- `IRWrite` out 1: load the instruction register.
- `NextPC` out 1: write PC+4 into the PC.
- `RegW` out 1: register file write.
- `MemW` out 1: memory write.
- `MemReq` out 1: memory access in progress.
- `Branch` out 1: branch target write to the PC.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALU result.
- `ALUSrcA` out 2: ALU A operand. 00 = Rn, 01 = PC, 10 = ALUOut.
- `ALUSrcB` out 2: ALU B operand. 00 = Rm, 01 = extended immediate, 10 = constant 4.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = read data, 10 = ALU result.
- `ALUOp` out 1: to the ALU decoder. 1 = data-processing operation, 0 = add.
- `Illegal` out 1: one-cycle pulse when DECODE sees `Op`=11.

## Operation
- The FSM has 10 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- All outputs are decoded from the current state (Moore). Any output not listed for a state is 0.
- Per-state outputs:
  - FETCH: AdrSrc=0, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, MemReq=1. IRWrite=1 and NextPC=1 only in the completing cycle.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10. This precomputes PC+8.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMREAD: AdrSrc=1, MemReq=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemReq=1, MemW=1.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUOp=1.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUOp=1.
  - ALUWB: ResultSrc=00, RegW=~NoWrite.
  - BRANCH: ALUSrcA=10, ALUSrcB=01, ResultSrc=10, Branch=1.
- Transitions:
  - FETCH→DECODE.
  - DECODE: `Op`=01→MEMADR; `Op`=00 with Funct[5]=0→EXECUTER; `Op`=00 with Funct[5]=1→EXECUTEI; `Op`=10→BRANCH; `Op`=11→FETCH with `Illegal`=1.
  - MEMADR: Funct[0]=1→MEMREAD, otherwise MEMWRITE.
  - MEMREAD→MEMWB→FETCH.
  - MEMWRITE→FETCH.
  - EXECUTER and EXECUTEI→ALUWB→FETCH.
  - BRANCH→FETCH.
- `Op` and `Funct` are sampled in DECODE and MEMADR only. The instruction register holds them stable afterwards.
- Unreachable state encodings go to FETCH on the next edge, with all outputs 0 while in them.

## Timing
- Reset:
  - A clock edge with `reset`=0 loads FETCH.
  - While `reset`=0, these outputs are forced to 0: IRWrite, NextPC, RegW, MemW, MemReq, Branch, Illegal.
  - Mux selects show the FETCH values.
  - Reset asserted mid-instruction aborts it at the next edge. No write enable is asserted in the abort cycle.
- Latency with zero wait states:
  - Branch: 3 cycles.
  - Data-processing (register or immediate) and STR: 4 cycles.
  - LDR: 5 cycles.
- Each memory wait cycle adds 1 cycle (`MEM_WAIT_EN` only).
- Memory handshake (`MEM_WAIT_EN`):
  - FETCH, MEMREAD and MEMWRITE hold while `MemReady`=0.
  - `MemReq`, and `MemW` in MEMWRITE, stay asserted throughout the hold.
  - IRWrite and NextPC assert only in the FETCH cycle where `MemReady`=1, which makes them exactly one-cycle pulses.
  - `MemReady` outside these states is ignored.
  - `MemReady`=1 in the first cycle gives zero-wait behaviour.

## Configuration
- `MULTICYCLE_MEM_WAIT_EN` defined: the `MemReady` handshake is active as described above.
- Not defined: `MemReady` is ignored and treated as 1. Every memory state lasts exactly one cycle, and IRWrite/NextPC are asserted for the whole FETCH cycle.
- The port list is identical in both builds.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, release, then run a data-processing instruction. All write enables are 0 during reset; FETCH IRWrite=1 occurs on the first cycle after release.
- ADD register: `Op`=00, `Funct`=001000. States FETCH, DECODE, EXECUTER, ALUWB. ALUOp=1 in EXECUTER; RegW=1 in ALUWB; 4 cycles total.
- CMP immediate: `Op`=00, `Funct`=110101, `NoWrite`=1. Path goes through EXECUTEI. ALUSrcB=01; RegW=0 in ALUWB.
- LDR with `MemReady` low for 2 cycles in MEMREAD (macro defined): MEMREAD lasts 3 cycles with AdrSrc=1 and MemReq=1. MEMWB then gives RegW=1 and ResultSrc=01; 7 cycles total.
- STR followed by B: `Op`=01 with Funct[0]=0 gives MemW=1 for exactly one MEMWRITE cycle. Then `Op`=10 gives BRANCH with ALUSrcA=10 and Branch=1; 3 cycles.
- `Op`=11 in DECODE gives an `Illegal` pulse for 1 cycle, then FETCH. Asserting reset in MEMWRITE gives MemW=0 in that cycle and FETCH next.
